hier_pipe_chain: RTL and testbench
==================================

Name: hier_pipe_chain

Overview:
- Parametrised successor to the hierarchical leaf/mid floorplan test designs.
- Contains STAGES register stages in a chain. Each stage applies one "swap-and-invert a bit pair" transform to the word passing through it.
- Stages are linked by an elastic valid/ready pipeline, so the fplan pass sees a regular, scalable hierarchy that carries real sequential state.
- Also reports occupancy and a count of completed transfers.

Parameters:
- WIDTH, 15, data word width; must be >= 2.
- STAGES, 4, number of pipeline stages; must be >= 1.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of all stage valid bits; data registers are don't-care.
- in_valid  in  1  producer has a word.
- in_data  in  WIDTH  input word.
- in_ready  out  1  stage 0 can accept this cycle.
- out_valid  out  1  last stage holds a word.
- out_data  out  WIDTH  word in last stage.
- out_ready  in  1  consumer takes the word this cycle.
- occupancy  out  $clog2(STAGES+1)  number of valid stages.
- xfer_count  out  CNT_W  completed output transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset==0 at an edge) clears every stage valid bit, occupancy and xfer_count to 0. out_valid is 0 the cycle after; out_data is don't-care while out_valid==0. Reset has priority over flush and over any handshake in the same cycle.
- Stage k, 0..STAGES-1, holds v[k] and d[k]. Stage 0 loads from in_data; stage k>0 loads from stage k-1.
- Transform T_k: let j = k mod (WIDTH/2). Bits 2j and 2j+1 of the incoming word are swapped and both inverted. All other bits pass unchanged. Stage k stores T_k(incoming word).
- ready[k] = !v[k] || ready[k+1]; ready[STAGES] = out_ready. in_ready = ready[0]. These are combinational, so full throughput is one word per cycle.
- Stage k loads when upstream is valid and ready[k]==1; v[k] is set. Otherwise, if ready[k+1]==1, v[k] is cleared; otherwise it holds.
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Latency:
  - With out_ready held high and no stalls, a word accepted at edge n appears with out_valid=1 after edge n+STAGES-1.
  - It is transferred at edge n+STAGES.
  - STAGES=1 gives out_valid in the cycle after acceptance.
- Back-pressure: with out_ready low, exactly STAGES words are accepted, then in_ready drops to 0. No word is lost or duplicated. Order is preserved.
- Simultaneous accept and transfer in a full chain: when out_ready rises, in_ready rises in the same cycle. At that edge one word is accepted and one leaves, so occupancy is unchanged.
- occupancy is the registered popcount of v[], updated the same edge as v[].
- xfer_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- flush==1 at an edge:
  - Clears all v[]. in_data offered that cycle is not accepted, and no output transfer is counted.
  - in_ready is forced to 0 during flush.
  - xfer_count is retained.
- in_valid may drop without a handshake and may change in_data while in_ready==0. The block only samples on a handshake.

Test Plan:
- Reset, then WIDTH=15, STAGES=4, one input 15'h0000 with out_ready=1 -> out_data=15'h00FF, out_valid for exactly one cycle, 4 edges after acceptance, xfer_count=1.
- Inputs 15'h0001 then 15'h00FF back-to-back -> outputs 15'h00FD then 15'h0000 on consecutive cycles; in_ready stays 1 throughout.
- out_ready=0, in_valid=1 with inputs 1..6 -> 4 accepted, in_ready=0, occupancy=4. Raise out_ready -> outputs T(1)..T(6) in order, none missing; final occupancy=0, xfer_count=6.
- Full chain, assert flush for one cycle -> occupancy=0 and out_valid=0 next cycle, xfer_count unchanged, in_ready=1 afterwards.
- reset=0 mid-stream (occupancy=3) while out_ready=1 -> no transfer counted that edge; occupancy=0, xfer_count=0.
- CNT_W=2, 5 transfers -> xfer_count sequence 1,2,3,0,1. STAGES=1, WIDTH=2: input 2'b01 -> output 2'b01, out_valid the cycle after acceptance.

Source files
------------

// File: rtl/hier_pipe_chain.sv
// Elastic valid/ready chain of STAGES registers; stage k swaps and inverts bit pair k mod (WIDTH/2).
// Also reports registered occupancy and a wrapping count of output transfers.
module hier_pipe_chain #(
    parameter int WIDTH  = 15,
    parameter int STAGES = 4,
    parameter int CNT_W  = 8,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] xfer_count
);

    function automatic logic [WIDTH-1:0] f_xform(input int k, input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] res;
        int j;
        j = k % (WIDTH / 2);
        res = w;
        res[2*j]   = ~w[2*j+1];
        res[2*j+1] = ~w[2*j];
        return res;
    endfunction

    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [OCC_W-1:0]  r_occ;
    logic [CNT_W-1:0]  r_cnt;

    logic [STAGES:0]   w_rdy;
    logic [STAGES-1:0] w_up_v;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_v_next;
    logic [WIDTH-1:0]  w_in [STAGES];
    logic              w_xfer;

    // A stage is ready if it or any stage downstream of it has a free slot.
    always_comb begin : p_rdy
        logic acc;
        acc = out_ready;
        w_rdy = '0;
        w_rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc = acc | ~r_v[k];
            w_rdy[k] = acc;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_up_v[k] = in_valid & ~flush;
            assign w_in[k]   = in_data;
        end else begin : g_body
            assign w_up_v[k] = r_v[k-1];
            assign w_in[k]   = r_d[k-1];
        end
        assign w_load[k] = w_up_v[k] & w_rdy[k];
    end

    always_comb begin
        w_v_next = r_v;
        for (int k = 0; k < STAGES; k++) begin
            if (flush)
                w_v_next[k] = 1'b0;
            else if (w_load[k])
                w_v_next[k] = 1'b1;
            else if (w_rdy[k+1])
                w_v_next[k] = 1'b0;
        end
    end

    assign w_xfer = r_v[STAGES-1] & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v   <= '0;
            r_occ <= '0;
            r_cnt <= '0;
        end else begin
            r_v   <= w_v_next;
            r_occ <= OCC_W'($countones(w_v_next));
            if (w_xfer)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Data registers carry no reset; contents only matter while valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (w_load[k])
                r_d[k] <= f_xform(k, w_in[k]);
        end
    end

    assign in_ready   = w_rdy[0] & ~flush;
    assign out_valid  = r_v[STAGES-1];
    assign out_data   = r_d[STAGES-1];
    assign occupancy  = r_occ;
    assign xfer_count = r_cnt;

endmodule

// File: tb/tb_hier_pipe_chain.sv
// Bench for hier_pipe_chain: vector table plus queue scoreboard,
// with directed sequences for back-pressure, flush, reset and counter wrap.
module tb_hier_pipe_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [14:0] in_data;
    logic        in_ready, out_valid;
    logic [14:0] out_data;
    logic [2:0]  occupancy;
    logic [7:0]  xfer_count;

    logic        in_ready1, out_valid1;
    logic [14:0] out_data1;
    logic [2:0]  occupancy1;
    logic [1:0]  xfer1;

    logic        in_valid2, out_ready2, in_ready2, out_valid2;
    logic [1:0]  in_data2, out_data2;
    logic [0:0]  occ2;
    logic [7:0]  xfer2;

    hier_pipe_chain #(.WIDTH(15), .STAGES(4), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy), .xfer_count(xfer_count)
    );

    hier_pipe_chain #(.WIDTH(15), .STAGES(4), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
        .occupancy(occupancy1), .xfer_count(xfer1)
    );

    hier_pipe_chain #(.WIDTH(2), .STAGES(1), .CNT_W(8)) u2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
        .occupancy(occ2), .xfer_count(xfer2)
    );

    typedef struct {
        logic [14:0] din;
        logic [14:0] dout;
    } vec_t;

    vec_t        tbl [8];
    logic [14:0] q [$];
    logic [14:0] sb_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_x;
    int          w;

    // Four stages touch pairs (0,1)..(6,7): each pair swapped and inverted.
    function automatic logic [14:0] model(input logic [14:0] x);
        logic [14:0] r;
        r = x;
        for (int p = 0; p < 4; p++) begin
            r[2*p]   = ~x[2*p+1];
            r[2*p+1] = ~x[2*p];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset || flush) begin
            q.delete();
        end else if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h expected no output", out_data);
            end else begin
                sb_e = q.pop_front();
                check("sb_data", {17'd0, out_data}, {17'd0, sb_e});
                check("sb_u1_data", {31'd0, out_valid1} << 15 | {17'd0, out_data1},
                      (32'd1 << 15) | {17'd0, sb_e});
            end
        end
    end

    task automatic send(input logic [14:0] d, input logic [14:0] e, output int waited);
        waited = 0;
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for %h", d);
        end else begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (occupancy != 0 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check("drain_occ", {29'd0, occupancy}, 0);
        check("drain_occ_u1", {29'd0, occupancy1}, 0);
        check("sb_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] seq [5];
        logic [1:0] last;
        logic [1:0] d2 [3];
        logic [1:0] e2 [3];
        int k;

        tbl[0] = '{15'h0000, 15'h00FF};
        tbl[1] = '{15'h7FFF, 15'h7F00};
        tbl[2] = '{15'h0055, 15'h0055};
        tbl[3] = '{15'h00AA, 15'h00AA};
        tbl[4] = '{15'h5A00, 15'h5AFF};
        tbl[5] = '{15'h0F0F, 15'h0FF0};
        tbl[6] = '{15'h0001, 15'h00FD};
        tbl[7] = '{15'h00FF, 15'h0000};
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
        d2[0] = 2'b01; e2[0] = 2'b01;
        d2[1] = 2'b00; e2[1] = 2'b11;
        d2[2] = 2'b11; e2[2] = 2'b00;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        exp_x = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_occ", {29'd0, occupancy}, 0);
        check("rst_xfer", {24'd0, xfer_count}, 0);
        check("rst_out_valid2", {31'd0, out_valid2}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single word: out_valid exactly once, 4 edges after acceptance
        send(15'h0000, 15'h00FF, w);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_out_valid", {31'd0, out_valid}, {31'd0, i == 3});
        end
        exp_x = 1;
        check("t1_xfer", {24'd0, xfer_count}, exp_x);
        check("t1_xfer_u1", {30'd0, xfer1}, exp_x % 4);
        @(posedge clk);
        #1;

        // Back-to-back pair
        send(15'h0001, 15'h00FD, w);
        check("t2_ready_a", w, 0);
        send(15'h00FF, 15'h0000, w);
        check("t2_ready_b", w, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_out_valid", {31'd0, out_valid}, {31'd0, (i == 2) || (i == 3)});
        end
        exp_x = 3;
        check("t2_xfer", {24'd0, xfer_count}, exp_x);
        @(posedge clk);
        #1;

        // Vector table streamed at full rate
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].din, tbl[i].dout, w);
            check("tbl_ready", w, 0);
        end
        in_valid = 1'b0;
        drain();
        exp_x += 8;
        check("tbl_xfer", {24'd0, xfer_count}, exp_x);
        check("tbl_xfer_u1", {30'd0, xfer1}, exp_x % 4);

        // Back-pressure, then simultaneous accept and transfer
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            send(15'(i), model(15'(i)), w);
        in_valid = 1'b1;
        in_data = 15'd5;
        repeat (2) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            check("bp_in_ready_u1", {31'd0, in_ready1}, 0);
            check("bp_occ", {29'd0, occupancy}, 4);
            check("bp_xfer", {24'd0, xfer_count}, exp_x);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(15'd5, model(15'd5), w);
        check("bp_same_cycle_ready", w, 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_occ_kept", {29'd0, occupancy}, 4);
        @(posedge clk);
        #1;
        send(15'd6, model(15'd6), w);
        in_valid = 1'b0;
        drain();
        exp_x += 6;
        check("bp_xfer_done", {24'd0, xfer_count}, exp_x);
        check("bp_xfer_u1", {30'd0, xfer1}, exp_x % 4);

        // Flush a full chain while the consumer is ready
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(15'h0100 + 15'(i), model(15'h0100 + 15'(i)), w);
        in_valid = 1'b1;
        in_data = 15'h1234;
        out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_in_ready_low", {31'd0, in_ready}, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_occ", {29'd0, occupancy}, 0);
        check("fl_out_valid", {31'd0, out_valid}, 0);
        check("fl_xfer", {24'd0, xfer_count}, exp_x);
        check("fl_in_ready", {31'd0, in_ready}, 1);
        repeat (3) begin
            @(negedge clk);
            check("fl_stays_empty", {31'd0, out_valid}, 0);
        end
        @(posedge clk);
        #1;

        // Reset mid-stream with the consumer ready
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(15'h0200 + 15'(i), model(15'h0200 + 15'(i)), w);
        in_valid = 1'b0;
        @(negedge clk);
        check("mr_occ3", {29'd0, occupancy}, 3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mr_occ", {29'd0, occupancy}, 0);
        check("mr_xfer", {24'd0, xfer_count}, 0);
        check("mr_out_valid", {31'd0, out_valid}, 0);
        exp_x = 0;
        @(posedge clk);
        #1;

        // Narrow counter wraps 1,2,3,0,1
        for (int i = 0; i < 5; i++)
            send(15'(i * 3), model(15'(i * 3)), w);
        in_valid = 1'b0;
        k = 0;
        last = 2'd0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (xfer1 != last && k < 5) begin
                check("cnt2_seq", {30'd0, xfer1}, {30'd0, seq[k]});
                last = xfer1;
                k++;
            end
        end
        check("cnt2_n", k, 5);
        check("cnt8_xfer", {24'd0, xfer_count}, 5);
        check("cnt_sb_empty", q.size(), 0);
        @(posedge clk);
        #1;

        // Single-stage, two-bit instance
        for (int i = 0; i < 3; i++) begin
            in_valid2 = 1'b1;
            in_data2 = d2[i];
            @(negedge clk);
            check("s1_in_ready", {31'd0, in_ready2}, 1);
            @(posedge clk);
            #1;
            in_valid2 = 1'b0;
            @(negedge clk);
            check("s1_out_valid", {31'd0, out_valid2}, 1);
            check("s1_out_data", {30'd0, out_data2}, {30'd0, e2[i]});
            check("s1_occ", {31'd0, occ2}, 1);
            @(negedge clk);
            check("s1_out_valid_off", {31'd0, out_valid2}, 0);
            check("s1_xfer", {24'd0, xfer2}, i + 1);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
